// File: rtl/count_seg7_display.sv
// Four-digit multiplexed 7-segment driver for a 4-bit up/down counter with carry/borrow indicators.
// Define SEG7_HEX_MODE_EN to show the count as a single hex digit instead of two decimal digits.
module count_seg7_display #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned HOLD_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic       qcc,
  input  logic       qcb,
  output logic [7:0] seg,
  output logic [3:0] an
);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

  localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);
  localparam logic [11:0] HOLD_LOAD = 12'(HOLD_TICKS);
  localparam logic [7:0]  SEG_BLANK = 8'h00;
  localparam logic [7:0]  SEG_C     = 8'h39;
  localparam logic [7:0]  SEG_B     = 8'h7C;

  logic [3:0]  count_q, count_d;
  logic        qcc_q, qcc_d, qcc_prev_q, qcc_prev_d;
  logic        qcb_q, qcb_d, qcb_prev_q, qcb_prev_d;
  logic [19:0] presc_q, presc_d;
  digit_e      scan_q, scan_d;
  logic [11:0] carry_hold_q, carry_hold_d;
  logic [11:0] borrow_hold_q, borrow_hold_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        tick;
  logic        carry_fall, borrow_fall;
  logic [7:0]  digit0_pat, digit1_pat;

  function automatic logic [7:0] hex_pat(input logic [3:0] v);
    logic [7:0] p;
    unique case (v)
      4'h0: p = 8'h3F;  4'h1: p = 8'h06;  4'h2: p = 8'h5B;  4'h3: p = 8'h4F;
      4'h4: p = 8'h66;  4'h5: p = 8'h6D;  4'h6: p = 8'h7D;  4'h7: p = 8'h07;
      4'h8: p = 8'h7F;  4'h9: p = 8'h6F;  4'hA: p = 8'h77;  4'hB: p = 8'h7C;
      4'hC: p = 8'h39;  4'hD: p = 8'h5E;  4'hE: p = 8'h79;  default: p = 8'h71;
    endcase
    return p;
  endfunction

  always_comb begin
    count_d    = count;
    qcc_d      = qcc;
    qcb_d      = qcb;
    qcc_prev_d = qcc_q;
    qcb_prev_d = qcb_q;

    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 20'd1;

    scan_d = scan_q;
    if (tick) begin
      unique case (scan_q)
        DIG0:    scan_d = DIG1;
        DIG1:    scan_d = DIG2;
        DIG2:    scan_d = DIG3;
        default: scan_d = DIG0;
      endcase
    end

    // A fresh falling edge reloads the full hold even if a hold is in progress.
    carry_fall  = qcc_prev_q & ~qcc_q;
    borrow_fall = qcb_prev_q & ~qcb_q;

    carry_hold_d = carry_hold_q;
    if (carry_fall)
      carry_hold_d = HOLD_LOAD;
    else if (tick && (carry_hold_q != '0))
      carry_hold_d = carry_hold_q - 12'd1;

    borrow_hold_d = borrow_hold_q;
    if (borrow_fall)
      borrow_hold_d = HOLD_LOAD;
    else if (tick && (borrow_hold_q != '0))
      borrow_hold_d = borrow_hold_q - 12'd1;

`ifdef SEG7_HEX_MODE_EN
    digit0_pat = hex_pat(count_q);
    digit1_pat = SEG_BLANK;
`else
    if (count_q >= 4'd10) begin
      digit0_pat = hex_pat(count_q - 4'd10);
      digit1_pat = hex_pat(4'd1);
    end else begin
      digit0_pat = hex_pat(count_q);
      digit1_pat = SEG_BLANK;
    end
`endif

    seg_d = SEG_BLANK;
    an_d  = 4'b0001;
    unique case (scan_q)
      DIG0: begin
        seg_d = digit0_pat;
        an_d  = 4'b0001;
      end
      DIG1: begin
        seg_d = digit1_pat;
        an_d  = 4'b0010;
      end
      DIG2: begin
        seg_d = (borrow_hold_q != '0) ? SEG_B : SEG_BLANK;
        an_d  = 4'b0100;
      end
      default: begin
        seg_d = (carry_hold_q != '0) ? SEG_C : SEG_BLANK;
        an_d  = 4'b1000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q       <= '0;
      qcc_q         <= 1'b1;
      qcb_q         <= 1'b1;
      qcc_prev_q    <= 1'b1;
      qcb_prev_q    <= 1'b1;
      presc_q       <= '0;
      scan_q        <= DIG0;
      carry_hold_q  <= '0;
      borrow_hold_q <= '0;
      seg_q         <= SEG_BLANK;
      an_q          <= 4'b0001;
    end else begin
      count_q       <= count_d;
      qcc_q         <= qcc_d;
      qcb_q         <= qcb_d;
      qcc_prev_q    <= qcc_prev_d;
      qcb_prev_q    <= qcb_prev_d;
      presc_q       <= presc_d;
      scan_q        <= scan_d;
      carry_hold_q  <= carry_hold_d;
      borrow_hold_q <= borrow_hold_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
